shift_arbiter: RTL
==================

Name: shift_arbiter

Overview:
Shares one barrel-shift datapath (left-logical, right-logical, right-arithmetic) between two requesters, e.g. the ALU issue path and the multiply/divide sequencer. Each requester has a valid/ready request channel and a valid/ready response channel. Arbitration is round-robin or fixed-priority. Operands are captured on accept and the result is registered. Each response is held until the owning requester takes it.

Parameters:
DATA_W, 32, operand/result width in bits
AMT_W, 5, shift-amount width; must equal log2(DATA_W)
FAIR, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  request 0 accepted this cycle when high together with req0_valid
req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 see Optional Feature
req0_a  in  DATA_W  operand
req0_amt  in  AMT_W  shift amount
req1_valid, req1_ready, req1_op, req1_a, req1_amt: same as requester 0
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 takes the result
rsp0_data  out  DATA_W  result for requester 0
rsp1_valid, rsp1_ready, rsp1_data: same as requester 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; all ready and valid outputs 0; rsp*_data=0; busy=0.
  - Round-robin pointer = requester 0 has priority.
  - Reset mid-operation discards any captured operation and any pending response.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with valid; if both are valid, grant = priority holder (FAIR=1) or requester 0 (FAIR=0).
  - reqN_ready = (state==IDLE) & grant==N; this is combinational from req*_valid.
  - On accept, capture op/a/amt/id and go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC, one cycle:
  - The shifter operates on the captured operands and its result is registered into rsp{id}_data.
  - rsp{id}_valid=1; go to RESP.
  - Round-robin pointer flips to the requester that was not served.
- RESP:
  - Hold rsp{id}_valid and data stable until rsp{id}_ready; then clear valid and return to IDLE.
  - rsp{id}_data holds its last value after valid drops.
  - The other requester's rsp valid stays 0.
- Latency: accept at edge N, rsp valid after edge N+1. If rsp_ready is already high, IDLE is reached after edge N+2, so peak throughput is one operation per 3 cycles.
- No request is accepted in EXEC or RESP; req*_ready=0 there.
- Requester inputs are not required to be held after the accept cycle.
- Arithmetic:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA replicates a[DATA_W-1].
  - amt=0 returns a unchanged.
  - amt is unsigned, range 0..DATA_W-1, no saturation.
- Simultaneous events:
  - Both requesters valid in IDLE: exactly one is granted.
  - A requester dropping valid without being accepted is legal; the grant is re-evaluated each IDLE cycle.

Optional Feature:
SHIFT_ARBITER_ROTATE_EN
- Defined: op 11 = rotate-left by amt; result = (a<<amt)|(a>>(DATA_W-amt)), and amt=0 returns a.
- Undefined: op 11 is reserved. It is accepted and completes with normal timing, and the result equals a unchanged.

Decomposition:
- Shared package shift_pkg:
  - op encodings SHIFT_OP_SLL=2'b00, SHIFT_OP_SRL=2'b01, SHIFT_OP_SRA=2'b10, SHIFT_OP_ROL=2'b11.
  - FSM state typedef (IDLE/EXEC/RESP).
  - Defaults for DATA_W/AMT_W.
- One sub-module: shift_unit, a combinational log-depth mux shifter (inputs a, amt, op; output result) that holds all shift-direction and fill logic. The arbiter contains only the FSM, capture registers and pointer.

Test Plan:
- Single request: req0 SLL a=0x0000_0001 amt=31 -> req0_ready high in the valid cycle; rsp0_valid one cycle later with rsp0_data=0x8000_0000; rsp1_valid stays 0.
- Arithmetic vs logical: req1 SRA a=0x8000_00F0 amt=4 -> 0xF800_000F; then SRL with the same operands -> 0x0800_000F; amt=0 returns 0x8000_00F0.
- Contention with FAIR=1: both requesters valid and held in consecutive IDLE windows -> grants alternate 0,1,0,1; with FAIR=0, requester 0 wins every grant.
- Backpressure: rsp0_ready held low for 5 cycles -> rsp0_valid and rsp0_data stable; req*_ready=0; busy=1 throughout; IDLE one cycle after rsp0_ready rises.
- Reset mid-op: drop reset_n while in RESP -> rsp*_valid=0 and state IDLE immediately (asynchronously); after release, a new req1 request completes normally.
- Op 11, a=0x1234_5678 amt=8: macro defined -> 0x3456_7812; macro undefined -> 0x1234_5678.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: op encodings, FSM states, default widths.
// Optional rotate support is selected by SHIFT_ARBITER_ROTATE_EN in shift_unit.
package shift_pkg;

  localparam int SHIFT_DATA_W = 32;
  localparam int SHIFT_AMT_W  = 5;

  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [1:0] SHIFT_OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational log-depth barrel shifter (SLL/SRL/SRA, op 11 rotate-left under SHIFT_ARBITER_ROTATE_EN,
// otherwise op 11 passes a through); zero latency, no flow control.
module shift_unit
  import shift_pkg::*;
#(
  parameter int DATA_W = SHIFT_DATA_W,
  parameter int AMT_W  = SHIFT_AMT_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);

  logic              rev;
  logic              rot;
  logic              fill;
  logic              bypass;
  logic [DATA_W-1:0] a_rev;
  logic [DATA_W-1:0] out_rev;
  logic [DATA_W-1:0] stage [AMT_W+1];

  always_comb begin
    rev    = 1'b0;
    rot    = 1'b0;
    fill   = 1'b0;
    bypass = 1'b0;
    case (op)
      SHIFT_OP_SLL: rev  = 1'b1;
      SHIFT_OP_SRL: fill = 1'b0;
      SHIFT_OP_SRA: fill = a[DATA_W-1];
      SHIFT_OP_ROL: begin
`ifdef SHIFT_ARBITER_ROTATE_EN
        rev = 1'b1;
        rot = 1'b1;
`else
        bypass = 1'b1;
`endif
      end
    endcase
  end

  // Left operations reuse the right-shift network on a bit-reversed operand.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign a_rev[i]   = a[DATA_W-1-i];
    assign out_rev[i] = stage[AMT_W][DATA_W-1-i];
  end

  assign stage[0] = rev ? a_rev : a;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    logic [SH-1:0] hi;
    assign hi         = rot ? stage[k][SH-1:0] : {SH{fill}};
    assign stage[k+1] = amt[k] ? {hi, stage[k][DATA_W-1:SH]} : stage[k];
  end

  assign result = bypass ? a : (rev ? out_rev : stage[AMT_W]);

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter for one shared shifter: accept in IDLE, result registered after one EXEC cycle.
// Each response is held in RESP until its owner takes it; no new request is accepted meanwhile.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DATA_W = SHIFT_DATA_W,
  parameter int AMT_W  = SHIFT_AMT_W,
  parameter int FAIR   = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              busy
);

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              take;
  logic              cap_id;
  logic [1:0]        cap_op;
  logic [DATA_W-1:0] cap_a;
  logic [AMT_W-1:0]  cap_amt;
  logic [DATA_W-1:0] result;

  // prio=1 hands contested grants to requester 1; ignored in fixed-priority mode.
  assign grant1 = req1_valid & (~req0_valid | ((FAIR != 0) & prio));
  assign grant0 = req0_valid & ~grant1;
  assign take   = cap_id ? rsp1_ready : rsp0_ready;
  assign busy   = (state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 & reset_n;
        req1_ready = grant1 & reset_n;
        accept     = grant0 | grant1;
        if (accept) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: if (take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio       <= 1'b0;
      cap_id     <= 1'b0;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_amt    <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_id  <= grant1;
            cap_op  <= grant1 ? req1_op  : req0_op;
            cap_a   <= grant1 ? req1_a   : req0_a;
            cap_amt <= grant1 ? req1_amt : req0_amt;
          end
        end
        EXEC: begin
          if (cap_id) begin
            rsp1_data  <= result;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_data  <= result;
            rsp0_valid <= 1'b1;
          end
          prio <= ~cap_id;
        end
        RESP: begin
          if (take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  shift_unit #(
    .DATA_W(DATA_W),
    .AMT_W (AMT_W)
  ) u_shift (
    .a     (cap_a),
    .amt   (cap_amt),
    .op    (cap_op),
    .result(result)
  );

endmodule
